// File: rtl/regfile_dump_reader.sv
// Debug read-out engine: walks a register-file address range through one read
// port and streams (address, data) beats over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; range checked here
// READ  | rd_addr settled, capture rd_data into the beat registers
// SEND  | beat presented, waiting for out_ready
// DONE  | one-cycle done pulse, start ignored
module regfile_dump_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   cur, cur_next;
  logic [ADDR_W-1:0]   last, last_next;
  logic [ADDR_W-1:0]   rd_addr_next, out_addr_next;
  logic [DATA_W-1:0]   out_data_next;
  logic                out_valid_next, out_last_next, err_next;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state     <= IDLE;
      cur       <= '0;
      last      <= '0;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_next;
      cur       <= cur_next;
      last      <= last_next;
      rd_addr   <= rd_addr_next;
      out_valid <= out_valid_next;
      out_addr  <= out_addr_next;
      out_data  <= out_data_next;
      out_last  <= out_last_next;
      busy      <= (state_next == READ) || (state_next == SEND);
      done      <= (state_next == DONE);
      err       <= err_next;
    end
  end

  always_comb begin
    state_next     = state;
    cur_next       = cur;
    last_next      = last;
    rd_addr_next   = rd_addr;
    out_valid_next = out_valid;
    out_addr_next  = out_addr;
    out_data_next  = out_data;
    out_last_next  = out_last;
    err_next       = 1'b0;

    // abort wins over start and over an accepting handshake in the same cycle
    if (abort) begin
      state_next     = IDLE;
      out_valid_next = 1'b0;
      out_last_next  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (first_addr <= last_addr) begin
              last_next    = last_addr;
              cur_next     = first_addr;
              rd_addr_next = first_addr;
              state_next   = READ;
            end else begin
              err_next = 1'b1;
            end
          end
        end
        READ: begin
          out_data_next  = rd_data;
          out_addr_next  = cur;
          out_last_next  = (cur == last);
          out_valid_next = 1'b1;
          state_next     = SEND;
        end
        SEND: begin
          if (out_valid && out_ready) begin
            out_valid_next = 1'b0;
            // terminal compare happens before the increment, so 0..max never wraps
            if (cur == last) begin
              state_next = DONE;
            end else begin
              cur_next     = cur + 1'b1;
              rd_addr_next = cur + 1'b1;
              state_next   = READ;
            end
          end
        end
        DONE: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: table of dump ranges plus hand-written
// reset, abort and busy-start sequences against a behavioural register file.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        arst;
  logic        start;
  logic [4:0]  first_addr, last_addr;
  logic        abort;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid, out_ready;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        out_last, busy, done, err;

  logic [31:0] rf [32];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rd_data = rf[rd_addr];

  regfile_dump_reader #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .arst(arst), .start(start), .first_addr(first_addr),
    .last_addr(last_addr), .abort(abort), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic [4:0] f;
    logic [4:0] l;
    int         stall;
    int         inj;
    int         exp_err;
    int         exp_beats;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int stall,
                          input int inj, input int exp_err, input int exp_beats);
    logic [31:0] snap [32];
    int exp_a, edges, beats, stall_cnt;
    bit fin, acc, v;
    snap = rf;
    @(negedge clk);
    first_addr = f; last_addr = l; start = 1'b1; out_ready = (stall == 0);
    @(posedge clk); #1;
    start = 1'b0; edges = 1;
    if (exp_err != 0) begin
      chk("err_pulse", {31'd0, err}, 1);
      chk("err_busy", {31'd0, busy}, 0);
      @(posedge clk); #1;
      chk("err_clear", {31'd0, err}, 0);
      repeat (3) begin
        chk("err_no_beat", {31'd0, out_valid}, 0);
        chk("err_no_busy", {31'd0, busy}, 0);
        @(posedge clk); #1;
      end
      return;
    end
    exp_a = f; beats = 0; stall_cnt = 0; fin = 0;
    while (!fin && edges < 400) begin
      chk("no_err", {31'd0, err}, 0);
      if (done) begin
        chk("done_edge", edges, 1 + exp_beats * (2 + stall));
        chk("beat_count", beats, exp_beats);
        chk("done_valid_low", {31'd0, out_valid}, 0);
        fin = 1;
      end else begin
        chk("busy_high", {31'd0, busy}, 1);
        v = out_valid;
        if (v) begin
          chk("out_addr", {27'd0, out_addr}, exp_a & 31);
          chk("out_data", out_data, snap[exp_a & 31]);
          chk("out_last", {31'd0, out_last}, {31'd0, (exp_a == int'(l))});
          out_ready = (stall_cnt >= stall);
          // disturb the read port during stalls; the held payload must not follow
          if (!out_ready) rf[exp_a & 31] = ~snap[exp_a & 31];
        end else begin
          out_ready = (stall == 0);
        end
        acc = v && out_ready;
        start = (inj == edges);
        if (start) begin first_addr = 5'd0; last_addr = 5'd31; end
        @(posedge clk); #1;
        edges++;
        start = 1'b0;
        if (acc) begin
          rf[exp_a & 31] = snap[exp_a & 31];
          beats++; exp_a++; stall_cnt = 0;
        end else if (v) begin
          stall_cnt++;
        end
      end
    end
    if (!fin) chk("done_timeout", 0, 1);
    start = (inj == edges);
    if (start) begin first_addr = 5'd0; last_addr = 5'd31; end
    @(posedge clk); #1;
    start = 1'b0;
    chk("post_busy", {31'd0, busy}, 0);
    chk("post_valid", {31'd0, out_valid}, 0);
    chk("post_done", {31'd0, done}, 0);
    rf = snap;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    arst = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    first_addr = '0; last_addr = '0;

    vecs[0] = '{f: 5'd0,  l: 5'd31, stall: 0, inj: 0, exp_err: 0, exp_beats: 32};
    vecs[1] = '{f: 5'd5,  l: 5'd7,  stall: 3, inj: 0, exp_err: 0, exp_beats: 3};
    vecs[2] = '{f: 5'd9,  l: 5'd9,  stall: 0, inj: 0, exp_err: 0, exp_beats: 1};
    vecs[3] = '{f: 5'd12, l: 5'd3,  stall: 0, inj: 0, exp_err: 1, exp_beats: 0};
    vecs[4] = '{f: 5'd10, l: 5'd11, stall: 0, inj: 3, exp_err: 0, exp_beats: 2};
    vecs[5] = '{f: 5'd2,  l: 5'd3,  stall: 0, inj: 5, exp_err: 0, exp_beats: 2};
    vecs[6] = '{f: 5'd31, l: 5'd31, stall: 1, inj: 0, exp_err: 0, exp_beats: 1};
    vecs[7] = '{f: 5'd0,  l: 5'd0,  stall: 0, inj: 0, exp_err: 0, exp_beats: 1};

    #12;
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_rd_addr", {27'd0, rd_addr}, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_done_err", {30'd0, done, err}, 0);
    @(negedge clk); arst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].f == 5'd9) rf[9] = 32'hDEADBEEF;
      run_dump(vecs[i].f, vecs[i].l, vecs[i].stall, vecs[i].inj,
               vecs[i].exp_err, vecs[i].exp_beats);
    end
    chk("reg9_value", rf[9], 32'hDEADBEEF);

    // abort on the addr-4 beat with the sink stalled
    @(negedge clk);
    first_addr = 5'd0; last_addr = 5'd31; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (!(out_valid && out_addr == 5'd4) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("abort_reach_addr4", {31'd0, (n < 50)}, 1);
    out_ready = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_valid", {31'd0, out_valid}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_last", {31'd0, out_last}, 0);
    repeat (4) begin
      chk("abort_no_done", {31'd0, done}, 0);
      @(posedge clk); #1;
    end
    run_dump(5'd2, 5'd3, 0, 0, 0, 2);

    // asynchronous reset in the middle of SEND
    @(negedge clk);
    first_addr = 5'd0; last_addr = 5'd31; start = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("pre_rst_valid", {31'd0, out_valid}, 1);
    arst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_rd_addr", {27'd0, rd_addr}, 0);
    chk("mid_rst_addr_data", {out_addr, out_data[26:0]}, 0);
    chk("mid_rst_flags", {29'd0, out_last, done, err}, 0);
    @(negedge clk); arst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", {31'd0, busy}, 0);
    run_dump(5'd6, 5'd8, 0, 0, 0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Debug read-out engine for the register file, on the read side of its ports.
- On a start request it walks a contiguous register address range through one register-file read port and captures each combinational read value.
- Each captured value is streamed out as an (address, data) beat over a valid/ready handshake to the debug/trace path.
- The core is expected to hold off writes to the register file while busy=1.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- clk  input  1  system clock, rising edge.
- arst  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- first_addr  input  ADDR_W  first register of range; sampled with start.
- last_addr  input  ADDR_W  last register of range, inclusive; sampled with start.
- abort  input  1  cancel the dump in progress.
- rd_addr  output  ADDR_W  drives a register-file read address port.
- rd_data  input  DATA_W  combinational read data for rd_addr.
- out_valid  output  1  beat available.
- out_ready  input  1  sink accepts beat.
- out_addr  output  ADDR_W  register index of the current beat.
- out_data  output  DATA_W  register value of the current beat.
- out_last  output  1  current beat is the final one of the range.
- busy  output  1  high in READ and SEND.
- done  output  1  one-cycle pulse after the final beat is accepted.
- err  output  1  one-cycle pulse when start has first_addr > last_addr.

Behaviour:
- Reset (arst low, async) forces:
  - state=IDLE
  - rd_addr=0, out_valid=0, out_addr=0, out_data=0, out_last=0
  - busy=0, done=0, err=0
  - all internal registers (cur, last) = 0
- State machine states: IDLE, READ, SEND, DONE.
- IDLE:
  - start=1 and first_addr<=last_addr: latch last_addr into last, set rd_addr=cur=first_addr, go to READ.
  - start=1 and first_addr>last_addr: err=1 for the next cycle, stay IDLE.
  - start=0: stay IDLE.
- READ (one cycle):
  - rd_addr is stable from the previous edge.
  - On the edge, register out_data<=rd_data, out_addr<=cur, out_last<=(cur==last), out_valid<=1.
  - Go to SEND.
- SEND:
  - Hold out_valid and the payload constant until out_valid&&out_ready.
  - On acceptance with cur==last: out_valid<=0, go to DONE.
  - On acceptance otherwise: cur<=cur+1, rd_addr<=cur+1, out_valid<=0, go to READ.
- DONE:
  - done=1 for exactly this one cycle, then return to IDLE.
  - A start in this cycle is ignored.
- Throughput: 2 cycles per beat with out_ready held high.
- Latency: start edge to first out_valid=1 is 2 edges.
- Range of N registers with ready always high: done pulses 2N+1 cycles after the start edge.
- busy=1 exactly in READ and SEND; it is registered, decoded from state.
- start while not IDLE: ignored, with no effect on range or state.
- abort=1 in any state:
  - Next edge: state=IDLE, out_valid=0, out_last=0, busy=0.
  - No done pulse.
  - abort has priority over start and over handshake acceptance in the same cycle.
- first_addr==last_addr: exactly one beat, with out_last=1.
- Full range 0..31: cur never wraps, because the terminal compare uses cur==last before any increment.
- Register 0 is read through the port like any other register; no special-casing.
- Changes on rd_data outside READ are ignored, so out_data never changes while out_valid=1.
- err and done are never asserted together.

Test Plan:
- Reset mid-dump: arst low while in SEND -> all outputs 0 immediately; after release, state IDLE and a new start behaves normally.
- Full dump, first=0, last=31, out_ready=1, regfile preloaded with data=0x1000+index:
  - 32 beats, out_addr 0..31, out_data 0x1000..0x101F.
  - out_last only on addr 31.
  - done pulse 65 cycles after the start edge.
- Backpressure, range 5..7, out_ready low for 3 cycles on each beat:
  - out_valid stays high and payload stays stable during stalls.
  - Beats 5, 6, 7 delivered in order, no duplicates or drops.
- Single register, first=last=9 with reg9=0xDEADBEEF -> one beat with out_addr=9, out_data=0xDEADBEEF, out_last=1, then done.
- Error and ignore cases:
  - start with first=12, last=3 -> err pulses once, busy stays 0, no beats.
  - start asserted while busy -> range unchanged, beat count unchanged.
- Abort, range 0..31: abort during the beat for addr 4 (out_ready low) -> next cycle out_valid=0, busy=0, no done; a following start with 2..3 dumps correctly.
